// File: rtl/ring_fetch_ctrl_pkg.sv
// Shared types and defaults for the ring buffer read-side fetch sequencer.
package ring_fetch_ctrl_pkg;

  localparam int unsigned APP_IDX_WIDTH = 4;
  localparam int unsigned PDU_DEPTH_DEF = 512;
  localparam int unsigned THRESHOLD_DEF = 64;
  localparam int unsigned FLIT_WIDTH    = 512;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [FLIT_WIDTH-1:0] data;
  } fetch_flit_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Register FIFO of fetch flits with first-word-fall-through output and an
// empty-bypass path so a returning flit can be accepted in its arrival cycle.
module fetch_skid_fifo
  import ring_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  fetch_flit_t      i_flit,
  input  logic             i_ready,
  output logic             o_valid,
  output fetch_flit_t      o_flit,
  output logic             o_pop,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_flit_t      r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty, w_wr, w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign o_valid = !w_empty || i_push;
  assign o_flit  = !w_empty ? r_mem[r_rd_ptr] : (i_push ? i_flit : '0);
  assign o_pop   = o_valid && i_ready;
  assign w_rd    = o_pop && !w_empty;
  // An arriving flit skips storage when the FIFO is empty and it is taken at once.
  assign w_wr    = i_push && !(w_empty && i_ready);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_flit;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ring_fetch_ctrl.sv
// Read-side sequencer: issues ring buffer reads for one DMA job and streams the flits out.
// Optional counters enabled by defining RING_FETCH_STATS_EN.
module ring_fetch_ctrl
  import ring_fetch_ctrl_pkg::*;
#(
  parameter int unsigned PDU_DEPTH  = PDU_DEPTH_DEF,
  parameter int unsigned PDU_AWIDTH = $clog2(PDU_DEPTH),
  parameter int unsigned THRESHOLD  = THRESHOLD_DEF,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_dma_start,
  input  logic [PDU_AWIDTH-1:0]    i_dma_base_addr,
  input  logic [PDU_AWIDTH-1:0]    i_dma_size,
  input  logic [APP_IDX_WIDTH-1:0] i_dma_queue,
  output logic                     o_dma_done,
  output logic                     o_rd_en,
  output logic [PDU_AWIDTH-1:0]    o_rd_addr,
  input  logic                     i_rd_valid,
  input  logic [FLIT_WIDTH-1:0]    i_rd_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [FLIT_WIDTH-1:0]    o_out_data,
  output logic                     o_out_sop,
  output logic                     o_out_eop,
  output logic [APP_IDX_WIDTH-1:0] o_out_queue,
  output logic                     o_err_busy,
  output logic                     o_err_zero
`ifdef RING_FETCH_STATS_EN
  ,
  output logic [31:0]              o_stat_jobs,
  output logic [31:0]              o_stat_flits,
  output logic [31:0]              o_stat_stall
`endif
);

  localparam int unsigned MAX_SLOT = PDU_DEPTH - THRESHOLD;
  localparam int unsigned CW       = PDU_AWIDTH + 1;
  localparam int unsigned FCW      = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_depth_chk
    $error("FIFO_DEPTH must cover RD_LATENCY + 2");
  end

  fetch_state_t             r_state, w_state_nxt;
  logic [PDU_AWIDTH-1:0]    r_cur_addr, r_rd_addr;
  logic [CW-1:0]            r_size, r_issued, r_outst, r_ret_idx, r_popped;
  logic [APP_IDX_WIDTH-1:0] r_queue;
  logic                     r_rd_en, r_done, r_err_busy, r_err_zero;

  logic                     w_start_ok, w_fetch_ok, w_issue, w_last_issue, w_last_pop;
  logic [PDU_AWIDTH-1:0]    w_issue_addr, w_next_addr;
  logic [CW-1:0]            w_issue_idx, w_issue_size, w_addr_inc;
  logic                     w_in_valid, w_out_valid, w_pop;
  fetch_flit_t              w_in_flit, w_head;
  logic [FCW-1:0]           w_fifo_count;

  // A job's first read is launched on the accepting edge to meet minimum latency.
  assign w_start_ok   = (r_state == IDLE) && i_dma_start && (i_dma_size != '0);
  assign w_fetch_ok   = (r_state == FETCH) && (r_issued < r_size) &&
                        ((r_outst + CW'(w_fifo_count)) < CW'(FIFO_DEPTH));
  assign w_issue      = w_start_ok || w_fetch_ok;
  assign w_issue_addr = w_start_ok ? i_dma_base_addr : r_cur_addr;
  assign w_issue_idx  = w_start_ok ? '0 : r_issued;
  assign w_issue_size = w_start_ok ? {1'b0, i_dma_size} : r_size;
  assign w_last_issue = w_issue && ((w_issue_idx + CW'(1)) == w_issue_size);
  assign w_addr_inc   = {1'b0, w_issue_addr} + CW'(1);
  assign w_next_addr  = (w_addr_inc >= CW'(MAX_SLOT)) ? '0 : w_addr_inc[PDU_AWIDTH-1:0];

  // Returns are only meaningful inside a job; stale ones after reset are dropped.
  assign w_in_valid     = i_rd_valid && (r_state != IDLE);
  assign w_in_flit.sop  = (r_ret_idx == '0);
  assign w_in_flit.eop  = (r_ret_idx == (r_size - CW'(1)));
  assign w_in_flit.data = i_rd_data;
  assign w_last_pop     = w_pop && ((r_popped + CW'(1)) == r_size);

  fetch_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_in_valid),
    .i_flit  (w_in_flit),
    .i_ready (i_out_ready),
    .o_valid (w_out_valid),
    .o_flit  (w_head),
    .o_pop   (w_pop),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = w_last_issue ? DRAIN : FETCH;
      FETCH:   if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
      r_rd_addr  <= '0;
      r_rd_en    <= 1'b0;
      r_size     <= '0;
      r_issued   <= '0;
      r_outst    <= '0;
      r_ret_idx  <= '0;
      r_popped   <= '0;
      r_queue    <= '0;
      r_done     <= 1'b0;
      r_err_busy <= 1'b0;
      r_err_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_en <= w_issue;
      r_done  <= w_last_pop || ((r_state == IDLE) && i_dma_start && (i_dma_size == '0));
      if (r_state == IDLE && i_dma_start) begin
        r_cur_addr <= i_dma_base_addr;
        r_size     <= {1'b0, i_dma_size};
        r_queue    <= i_dma_queue;
        r_issued   <= '0;
        r_ret_idx  <= '0;
        r_popped   <= '0;
        if (i_dma_size == '0) r_err_zero <= 1'b1;
      end
      if (r_state != IDLE && i_dma_start) r_err_busy <= 1'b1;
      if (w_issue) begin
        r_rd_addr  <= w_issue_addr;
        r_cur_addr <= w_next_addr;
        r_issued   <= w_issue_idx + CW'(1);
      end
      case ({w_issue, w_in_valid})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_in_valid) r_ret_idx <= r_ret_idx + CW'(1);
      if (w_pop)      r_popped  <= r_popped + CW'(1);
    end
  end

  assign o_dma_done  = r_done;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = w_head.data;
  assign o_out_sop   = w_head.sop;
  assign o_out_eop   = w_head.eop;
  assign o_out_queue = r_queue;
  assign o_err_busy  = r_err_busy;
  assign o_err_zero  = r_err_zero;

`ifdef RING_FETCH_STATS_EN
  logic [31:0] r_stat_jobs, r_stat_flits, r_stat_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_jobs  <= '0;
      r_stat_flits <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_done && (r_size != '0) && (r_stat_jobs != '1)) r_stat_jobs <= r_stat_jobs + 32'd1;
      if (w_pop && (r_stat_flits != '1)) r_stat_flits <= r_stat_flits + 32'd1;
      if (w_out_valid && !i_out_ready && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign o_stat_jobs  = r_stat_jobs;
  assign o_stat_flits = r_stat_flits;
  assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_ring_fetch_ctrl.sv
// Directed bench for ring_fetch_ctrl with a 2-cycle ring buffer read model.
module tb_ring_fetch_ctrl;
  import ring_fetch_ctrl_pkg::*;

  localparam int unsigned AW         = 9;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_dma_start = 1'b0;
  logic [AW-1:0]            i_dma_base_addr = '0;
  logic [AW-1:0]            i_dma_size = '0;
  logic [APP_IDX_WIDTH-1:0] i_dma_queue = '0;
  logic                     o_dma_done, o_rd_en;
  logic [AW-1:0]            o_rd_addr;
  logic                     i_rd_valid;
  logic [FLIT_WIDTH-1:0]    i_rd_data;
  logic                     o_out_valid;
  logic                     i_out_ready = 1'b0;
  logic [FLIT_WIDTH-1:0]    o_out_data;
  logic                     o_out_sop, o_out_eop;
  logic [APP_IDX_WIDTH-1:0] o_out_queue;
  logic                     o_err_busy, o_err_zero;
`ifdef RING_FETCH_STATS_EN
  logic [31:0]              o_stat_jobs, o_stat_flits, o_stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  ring_fetch_ctrl dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_dma_start     (i_dma_start),
    .i_dma_base_addr (i_dma_base_addr),
    .i_dma_size      (i_dma_size),
    .i_dma_queue     (i_dma_queue),
    .o_dma_done      (o_dma_done),
    .o_rd_en         (o_rd_en),
    .o_rd_addr       (o_rd_addr),
    .i_rd_valid      (i_rd_valid),
    .i_rd_data       (i_rd_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_out_sop       (o_out_sop),
    .o_out_eop       (o_out_eop),
    .o_out_queue     (o_out_queue),
    .o_err_busy      (o_err_busy),
    .o_err_zero      (o_err_zero)
`ifdef RING_FETCH_STATS_EN
    ,
    .o_stat_jobs     (o_stat_jobs),
    .o_stat_flits    (o_stat_flits),
    .o_stat_stall    (o_stat_stall)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [FLIT_WIDTH-1:0] mk_data(input logic [AW-1:0] a);
    return {496'd0, 7'h5A, a};
  endfunction

  // Ring buffer model: data returns two cycles after the strobe, regardless of reset.
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0, p2_a = '0;
  always @(posedge i_clk) begin
    p1_v <= o_rd_en;
    p1_a <= o_rd_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign i_rd_valid = p2_v;
  assign i_rd_data  = mk_data(p2_a);

  int   max_cnt  = 0;
  logic ovf_seen = 1'b0;
  always @(negedge i_clk) begin
    if (int'(dut.u_fifo.r_count) > max_cnt) max_cnt <= int'(dut.u_fifo.r_count);
    if (!i_rst && dut.u_fifo.w_wr && (int'(dut.u_fifo.r_count) >= FIFO_DEPTH)) ovf_seen <= 1'b1;
  end

  task automatic step(input logic rdy);
    @(posedge i_clk);
    #1;
    i_dma_start = 1'b0;
    i_out_ready = rdy;
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input logic [APP_IDX_WIDTH-1:0] q, input logic rdy);
    i_dma_start     = 1'b1;
    i_dma_base_addr = b;
    i_dma_size      = s;
    i_dma_queue     = q;
    step(rdy);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) step(1'b0);
    checks++; if (o_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", o_rd_en); end
    checks++; if (o_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", o_rd_addr); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
    checks++; if (o_dma_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_dma_done); end
    checks++; if ({o_out_sop, o_out_eop, o_out_queue} !== '0) begin errors++; $display("FAIL reset_tags: got %b%b q=%0d want 0", o_out_sop, o_out_eop, o_out_queue); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", o_out_data[15:0]); end
    checks++; if ({o_err_busy, o_err_zero} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b%b want 00", o_err_busy, o_err_zero); end
    i_rst = 1'b0;
    step(1'b0);
  endtask

  task automatic test_single();
    start_job(9'd10, 9'd1, 4'd3, 1'b1);
    checks++; if ({o_rd_en, o_rd_addr} !== {1'b1, 9'd10}) begin errors++; $display("FAIL single_rd_c1: got en=%b addr=%0d want en=1 addr=10", o_rd_en, o_rd_addr); end
    step(1'b1);
    checks++; if ({o_rd_en, o_out_valid} !== 2'b00) begin errors++; $display("FAIL single_c2: got en=%b valid=%b want 0 0", o_rd_en, o_out_valid); end
    step(1'b1);
    checks++; if ({o_out_valid, o_out_sop, o_out_eop} !== 3'b111) begin errors++; $display("FAIL single_flags_c3: got %b%b%b want 111", o_out_valid, o_out_sop, o_out_eop); end
    checks++; if (o_out_data !== mk_data(9'd10)) begin errors++; $display("FAIL single_data_c3: got %0h want %0h", o_out_data[15:0], 16'hB40A); end
    checks++; if (o_out_queue !== 4'd3) begin errors++; $display("FAIL single_queue: got %0d want 3", o_out_queue); end
    checks++; if (o_dma_done !== 1'b0) begin errors++; $display("FAIL single_early_done: got %b want 0", o_dma_done); end
    step(1'b1);
    checks++; if ({o_dma_done, o_out_valid} !== 2'b10) begin errors++; $display("FAIL single_done_c4: got done=%b valid=%b want 1 0", o_dma_done, o_out_valid); end
    step(1'b1);
    checks++; if (o_dma_done !== 1'b0) begin errors++; $display("FAIL single_done_c5: got %b want 0", o_dma_done); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [5] = '{9'd446, 9'd447, 9'd0, 9'd1, 9'd2};
    int n_iss = 0, n_pop = 0, n_done = 0, done_cyc = -1;
    start_job(9'd446, 9'd5, 4'd2, 1'b1);
    for (int c = 1; c < 20; c++) begin
      if (o_rd_en) begin
        checks++;
        if (n_iss >= 5) begin errors++; $display("FAIL wrap_extra_rd: got addr %0d want none", o_rd_addr); end
        else if (o_rd_addr !== exp_a[n_iss]) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %0d want %0d", n_iss, o_rd_addr, exp_a[n_iss]); end
        n_iss++;
      end
      if (o_out_valid) begin
        checks++;
        if (n_pop >= 5) begin errors++; $display("FAIL wrap_extra_flit: got data %0h want none", o_out_data[15:0]); end
        else if ({o_out_sop, o_out_eop, o_out_queue, o_out_data} !==
                 {n_pop == 0, n_pop == 4, 4'd2, mk_data(exp_a[n_pop])}) begin
          errors++; $display("FAIL wrap_flit[%0d]: got sop=%b eop=%b q=%0d d=%0h want sop=%b eop=%b q=2 d=%0h",
                             n_pop, o_out_sop, o_out_eop, o_out_queue, o_out_data[15:0], n_pop == 0, n_pop == 4, {7'h5A, exp_a[n_pop]});
        end
        n_pop++;
      end
      if (o_dma_done) begin n_done++; done_cyc = c; end
      step(1'b1);
    end
    checks++; if (n_iss != 5) begin errors++; $display("FAIL wrap_reads: got %0d want 5", n_iss); end
    checks++; if (n_pop != 5) begin errors++; $display("FAIL wrap_pops: got %0d want 5", n_pop); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL wrap_done_count: got %0d want 1", n_done); end
    // Flits pop in cycles 3..7 at full rate, so completion lands in cycle 8.
    checks++; if (done_cyc != 8) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 8", done_cyc); end
  endtask

  task automatic test_backpressure();
    int n_iss = 0, n_pop = 0, n_done = 0, last_pop = -10, done_cyc = -1;
    start_job(9'd100, 9'd8, 4'd6, 1'b1);
    for (int c = 1; c < 60; c++) begin
      if (o_rd_en) begin
        checks++;
        if (o_rd_addr !== 9'(100 + n_iss)) begin errors++; $display("FAIL bp_rd_addr[%0d]: got %0d want %0d", n_iss, o_rd_addr, 100 + n_iss); end
        n_iss++;
      end
      if (o_out_valid && i_out_ready) begin
        checks++;
        if ({o_out_sop, o_out_eop, o_out_data} !== {n_pop == 0, n_pop == 7, mk_data(9'(100 + n_pop))}) begin
          errors++; $display("FAIL bp_flit[%0d]: got sop=%b eop=%b d=%0h want sop=%b eop=%b addr=%0d",
                             n_pop, o_out_sop, o_out_eop, o_out_data[15:0], n_pop == 0, n_pop == 7, 100 + n_pop);
        end
        n_pop++;
        last_pop = c;
      end
      if (o_dma_done) begin n_done++; done_cyc = c; end
      step(((c + 1) % 2) == 1);
    end
    checks++; if (n_iss != 8) begin errors++; $display("FAIL bp_reads: got %0d want 8", n_iss); end
    checks++; if (n_pop != 8) begin errors++; $display("FAIL bp_pops: got %0d want 8", n_pop); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", n_done); end
    checks++; if (done_cyc != last_pop + 1) begin errors++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, last_pop + 1); end
    checks++; if (max_cnt > FIFO_DEPTH) begin errors++; $display("FAIL bp_max_buffered: got %0d want <= %0d", max_cnt, FIFO_DEPTH); end
    checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b want 0", ovf_seen); end
  endtask

  task automatic test_busy();
    int n_iss = 0, n_pop = 0, n_done = 0;
    checks++; if (o_err_busy !== 1'b0) begin errors++; $display("FAIL busy_pre: got %b want 0", o_err_busy); end
    start_job(9'd200, 9'd6, 4'd5, 1'b1);
    for (int c = 1; c < 30; c++) begin
      if (o_rd_en) begin
        checks++;
        if (o_rd_addr !== 9'(200 + n_iss)) begin errors++; $display("FAIL busy_rd_addr[%0d]: got %0d want %0d", n_iss, o_rd_addr, 200 + n_iss); end
        n_iss++;
      end
      if (o_out_valid) begin
        checks++;
        if ({o_out_queue, o_out_data} !== {4'd5, mk_data(9'(200 + n_pop))}) begin
          errors++; $display("FAIL busy_flit[%0d]: got q=%0d d=%0h want q=5 addr=%0d", n_pop, o_out_queue, o_out_data[15:0], 200 + n_pop);
        end
        n_pop++;
      end
      if (o_dma_done) n_done++;
      if (c == 2) begin
        i_dma_start     = 1'b1;
        i_dma_base_addr = 9'd300;
        i_dma_size      = 9'd3;
        i_dma_queue     = 4'd7;
      end
      step(1'b1);
    end
    checks++; if (o_err_busy !== 1'b1) begin errors++; $display("FAIL busy_flag: got %b want 1", o_err_busy); end
    checks++; if (n_iss != 6) begin errors++; $display("FAIL busy_reads: got %0d want 6", n_iss); end
    checks++; if (n_pop != 6) begin errors++; $display("FAIL busy_pops: got %0d want 6", n_pop); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_midjob();
    int n_pop = 0, n_done = 0, guard = 0, stray = 0;
    start_job(9'd20, 9'd6, 4'd9, 1'b1);
    while (n_pop < 3 && guard < 20) begin
      if (o_out_valid) n_pop++;
      guard++;
      step(n_pop < 3);
    end
    checks++; if (n_pop != 3) begin errors++; $display("FAIL rstmid_reach3: got %0d pops want 3", n_pop); end
    i_rst = 1'b1;
    step(1'b0);
    checks++; if ({o_rd_en, o_dma_done, o_out_valid, o_out_sop, o_out_eop} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctl: got en=%b done=%b valid=%b sop=%b eop=%b want all 0", o_rd_en, o_dma_done, o_out_valid, o_out_sop, o_out_eop);
    end
    checks++; if ({o_out_queue, o_out_data} !== '0) begin errors++; $display("FAIL rstmid_data: got q=%0d d=%0h want 0", o_out_queue, o_out_data[15:0]); end
    checks++; if ({o_err_busy, o_err_zero} !== 2'b00) begin errors++; $display("FAIL rstmid_err: got %b%b want 00", o_err_busy, o_err_zero); end
    i_rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1);
      if (o_out_valid || o_dma_done || o_rd_en) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_late_returns: got %0d active cycles want 0", stray); end
    n_pop = 0;
    start_job(9'd30, 9'd2, 4'd1, 1'b1);
    for (int c = 1; c < 15; c++) begin
      if (o_out_valid) begin
        checks++;
        if ({o_out_sop, o_out_eop, o_out_queue, o_out_data} !== {n_pop == 0, n_pop == 1, 4'd1, mk_data(9'(30 + n_pop))}) begin
          errors++; $display("FAIL rstmid_new_flit[%0d]: got sop=%b eop=%b q=%0d d=%0h want addr %0d", n_pop, o_out_sop, o_out_eop, o_out_queue, o_out_data[15:0], 30 + n_pop);
        end
        n_pop++;
      end
      if (o_dma_done) n_done++;
      step(1'b1);
    end
    checks++; if (n_pop != 2) begin errors++; $display("FAIL rstmid_new_pops: got %0d want 2", n_pop); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL rstmid_new_done: got %0d want 1", n_done); end
    checks++; if (ovf_seen !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b want 0", ovf_seen); end
  endtask

  task automatic test_zero();
    start_job(9'd5, 9'd0, 4'd2, 1'b1);
    checks++; if ({o_dma_done, o_err_zero, o_rd_en} !== 3'b110) begin
      errors++; $display("FAIL zero_c1: got done=%b err_zero=%b en=%b want 1 1 0", o_dma_done, o_err_zero, o_rd_en);
    end
    step(1'b1);
    checks++; if ({o_dma_done, o_rd_en, o_out_valid, o_err_zero} !== 4'b0001) begin
      errors++; $display("FAIL zero_c2: got done=%b en=%b valid=%b err_zero=%b want 0 0 0 1", o_dma_done, o_rd_en, o_out_valid, o_err_zero);
    end
    step(1'b1);
    checks++; if (o_rd_en !== 1'b0) begin errors++; $display("FAIL zero_no_read: got %b want 0", o_rd_en); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_busy();
    test_reset_midjob();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/ring_fetch_ctrl.md
Name: ring_fetch_ctrl

Overview:
- Read-side sequencer for the packet ring buffer.
- Accepts one DMA job (start, base address, size in flits, queue id) from the ring buffer's DMA interface and issues `rd_en`/`rd_addr` to its fetch port.
- Absorbs the 2-cycle read latency in an internal skid FIFO, presents the flits downstream on a valid/ready stream tagged with sop/eop/queue, and pulses `dma_done` once the last flit of the job is accepted downstream.

Parameters:
- PDU_DEPTH, 512, ring buffer depth in flits.
- PDU_AWIDTH, $clog2(PDU_DEPTH), flit address width.
- THRESHOLD, 64, reserved tail region; localparam MAX_SLOT = PDU_DEPTH - THRESHOLD is the wrap point.
- RD_LATENCY, 2, cycles from `rd_en` to `rd_valid`.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LATENCY + 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dma_start  in  1  one-cycle job request.
- dma_base_addr  in  PDU_AWIDTH  first flit address.
- dma_size  in  PDU_AWIDTH  job length in flits.
- dma_queue  in  APP_IDX_WIDTH  destination queue.
- dma_done  out  1  one-cycle pulse when the job completes.
- rd_en  out  1  read strobe to the ring buffer.
- rd_addr  out  PDU_AWIDTH  read address.
- rd_valid  in  1  read data valid, RD_LATENCY cycles after `rd_en`.
- rd_data  in  512  read flit data.
- out_valid  out  1  downstream flit valid.
- out_ready  in  1  downstream accept.
- out_data  out  512  flit payload.
- out_sop  out  1  first flit of the job.
- out_eop  out  1  last flit of the job.
- out_queue  out  APP_IDX_WIDTH  queue id of the job.
- err_busy  out  1  sticky: `dma_start` arrived while not IDLE.
- err_zero  out  1  sticky: `dma_start` arrived with `dma_size` == 0.

Behaviour:
- Reset: state IDLE.
  - `rd_en`, `rd_addr`, `dma_done`, `out_valid`, `out_sop`, `out_eop`, `out_queue`, `out_data`, `err_busy`, `err_zero` all 0.
  - FIFO flushed; issued, outstanding and popped counters all 0.
  - Reset mid-job aborts silently: no `dma_done`; in-flight `rd_valid` returns are discarded.
- Job latch: in IDLE, `dma_start` latches base (as `cur_addr`), size, queue, and clears the counters.
  - size > 0: go to FETCH.
  - size == 0: set `err_zero`, pulse `dma_done` the next cycle, stay IDLE.
- FETCH: each cycle, assert `rd_en` with `rd_addr` = `cur_addr` when issued < size and (outstanding + fifo_count) < FIFO_DEPTH.
  - `rd_en`/`rd_addr` are registered outputs.
  - Per issue: issued += 1; `cur_addr` = (`cur_addr` + 1 >= MAX_SLOT) ? 0 : `cur_addr` + 1.
  - When the final read is issued, go to DRAIN.
- Outstanding counter: +1 on `rd_en`, -1 on `rd_valid`; simultaneous events cancel.
- Each `rd_valid` pushes {`rd_data`, sop, eop} into the FIFO.
  - sop = (return index == 0).
  - eop = (return index == size-1).
  - Return index counts `rd_valid` beats in the job.
- The FIFO never overflows by construction. A push while full is a design error; the bench asserts on it.
- Output: `out_valid` = FIFO non-empty; `out_*` = FIFO head (first-word-fall-through); `out_queue` = latched queue.
  - Pop on `out_valid` && `out_ready`; popped += 1.
  - Push and pop in the same cycle leave fifo_count unchanged.
- DRAIN: when the pop of the eop flit occurs, pulse `dma_done` the next cycle and return to IDLE.
  - The job exits DRAIN only after the eop pop.
  - A new `dma_start` is accepted in the cycle after `dma_done`.
- Minimum latency, `out_ready` = 1, size 1: `dma_start` @0 → `rd_en` @1 → `rd_valid` @3 → pop @3 → `dma_done` @4.
  - This meets the ring buffer's >= 3-cycle `dma_done` requirement.
  - Throughput is 1 flit/cycle under continuous `out_ready`.
- `dma_start` in FETCH or DRAIN: ignored; set `err_busy`.
- Width rules: counters are PDU_AWIDTH+1 bits; size <= MAX_SLOT.

Optional Feature:
- Macro: RING_FETCH_STATS_EN.
- When defined: adds outputs `stat_jobs[31:0]` (+1 per `dma_done` of a nonzero job) and `stat_flits[31:0]` (+1 per pop) plus `stat_stall[31:0]` (+1 per cycle with `out_valid` && !`out_ready`). All three are zero on reset and saturate at all-ones.
- When undefined: ports and logic absent; remaining behaviour identical.

Decomposition:
- Shared package: APP_IDX_WIDTH, PDU_DEPTH/THRESHOLD defaults, fetch_state_t enum {IDLE, FETCH, DRAIN}, and a packed fetch_flit_t {sop, eop, data[511:0]}.
- One sub-module: `fetch_skid_fifo`, a parameterized register FIFO of fetch_flit_t with count output and first-word-fall-through behaviour.

Test Plan:
- Base 10, size 1, `out_ready`=1 → `rd_addr` 10 @1; one flit with sop=eop=1 @3; `dma_done` @4.
- Base 446, size 5 (MAX_SLOT 448) → `rd_addr` sequence 446, 447, 0, 1, 2; sop on the first flit, eop on the fifth; `dma_done` one cycle after the fifth pop.
- Size 8 with `out_ready` toggling 1-0-1-0 → never more than 4 flits buffered; no FIFO overflow; all 8 flits in order; `dma_done` once.
- `dma_start` issued again during FETCH of a size-6 job → second request ignored; `err_busy`=1; only 6 flits emitted.
- `rst` asserted after 3 of 6 flits → all outputs 0 next cycle; late `rd_valid` returns are dropped; no `dma_done`; a fresh size-2 job then completes normally.
- `dma_start` with size 0 → `err_zero`=1; `dma_done` the next cycle; no `rd_en`.
